// File: rtl/leg_uart_loader_if.sv
// Memory write port and status outputs of the LEG firmware loader.
// The loader drives the master side; the processor/memory side uses slave.
interface leg_uart_loader_if #(
    parameter int ADDR_W = 5
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              cpu_run;
    logic              load_done;
    logic              frame_err;

    modport master (
        output mem_we, mem_addr, mem_wdata, cpu_run, load_done, frame_err
    );
    modport slave (
        input  mem_we, mem_addr, mem_wdata, cpu_run, load_done, frame_err
    );
endinterface

// File: rtl/leg_uart_loader.sv
// UART (8N1) firmware loader: parses SYNC,BASE,LEN,data frames into LEG memory.
// Define LEG_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte.
module leg_uart_loader #(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          MEM_DEPTH    = 32,
    parameter int          ADDR_W       = 5,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              uart_rx_i,
    leg_uart_loader_if.master mem_if_o
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int REM_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {
        WAIT_SYNC, GET_BASE, GET_LEN, GET_DATA,
`ifdef LEG_LOADER_CHECKSUM_EN
        GET_SUM,
`endif
        DONE
    } ps_state_t;

    // rx_prev_q lags rx_s2_q by one cycle so only a true high->low edge starts a byte
    logic rx_s1_q, rx_s2_q, rx_prev_q;

    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_err_q, rx_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_s1_q    <= uart_rx_i;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (rx_prev_q && !rx_s2_q) rx_state_d = RX_START;
            end
            RX_START: if (cnt_q == CNT_HALF) begin
                cnt_d      = '0;
                rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (cnt_q == CNT_FULL) begin
                cnt_d   = '0;
                shreg_d = {rx_s2_q, shreg_q[7:1]};
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'd7) rx_state_d = RX_STOP;
            end
            RX_STOP: if (cnt_q == CNT_FULL) begin
                cnt_d      = '0;
                rx_state_d = RX_IDLE;
                rx_valid_d = rx_s2_q;
                rx_err_d   = !rx_s2_q;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    ps_state_t         ps_q, ps_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic              cpu_run_q, cpu_run_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              load_done_q, load_done_d;
    logic              frame_err_q, frame_err_d;
`ifdef LEG_LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
    localparam ps_state_t AFTER_DATA = GET_SUM;
`else
    localparam ps_state_t AFTER_DATA = DONE;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_q        <= WAIT_SYNC;
            ptr_q       <= '0;
            rem_q       <= '0;
            cpu_run_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            load_done_q <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef LEG_LOADER_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            ps_q        <= ps_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            cpu_run_q   <= cpu_run_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            load_done_q <= load_done_d;
            frame_err_q <= frame_err_d;
`ifdef LEG_LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    always_comb begin
        ps_d        = ps_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        cpu_run_d   = cpu_run_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        load_done_d = 1'b0;
        frame_err_d = 1'b0;
`ifdef LEG_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        if (rx_err_q) begin
            frame_err_d = 1'b1;
            ps_d        = WAIT_SYNC;
        end else begin
            unique case (ps_q)
                WAIT_SYNC: if (rx_valid_q && shreg_q == SYNC_BYTE) begin
                    ps_d      = GET_BASE;
                    cpu_run_d = 1'b0;
                end
                GET_BASE: if (rx_valid_q) begin
                    ptr_d = shreg_q[ADDR_W-1:0];
`ifdef LEG_LOADER_CHECKSUM_EN
                    sum_d = shreg_q;
`endif
                    ps_d  = GET_LEN;
                end
                GET_LEN: if (rx_valid_q) begin
`ifdef LEG_LOADER_CHECKSUM_EN
                    sum_d = sum_q + shreg_q;
`endif
                    if (shreg_q == 8'd0) begin
                        ps_d = AFTER_DATA;
                    end else if (int'(shreg_q) > MEM_DEPTH) begin
                        frame_err_d = 1'b1;
                        ps_d        = WAIT_SYNC;
                    end else begin
                        rem_d = REM_W'(shreg_q);
                        ps_d  = GET_DATA;
                    end
                end
                GET_DATA: if (rx_valid_q) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ptr_q;
                    mem_wdata_d = shreg_q;
                    ptr_d       = ptr_q + ADDR_W'(1);
                    rem_d       = rem_q - REM_W'(1);
`ifdef LEG_LOADER_CHECKSUM_EN
                    sum_d       = sum_q + shreg_q;
`endif
                    if (rem_q == REM_W'(1)) ps_d = AFTER_DATA;
                end
`ifdef LEG_LOADER_CHECKSUM_EN
                GET_SUM: if (rx_valid_q) begin
                    if (shreg_q == sum_q) begin
                        ps_d = DONE;
                    end else begin
                        frame_err_d = 1'b1;
                        ps_d        = WAIT_SYNC;
                    end
                end
`endif
                DONE: begin
                    load_done_d = 1'b1;
                    cpu_run_d   = 1'b1;
                    ps_d        = WAIT_SYNC;
                end
                default: ps_d = WAIT_SYNC;
            endcase
        end
    end

    assign mem_if_o.mem_we    = mem_we_q;
    assign mem_if_o.mem_addr  = mem_addr_q;
    assign mem_if_o.mem_wdata = mem_wdata_q;
    assign mem_if_o.cpu_run   = cpu_run_q;
    assign mem_if_o.load_done = load_done_q;
    assign mem_if_o.frame_err = frame_err_q;
endmodule

// File: tb/tb_leg_uart_loader.sv
// Directed bench for leg_uart_loader: serialises frames onto uart_rx and
// checks the logged memory writes and status pulses against hand-computed values.
module tb_leg_uart_loader;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic uart_rx = 1'b1;

    leg_uart_loader_if #(.ADDR_W(5)) bus ();

    leg_uart_loader #(
        .CLKS_PER_BIT(CPB),
        .MEM_DEPTH(32),
        .ADDR_W(5),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .uart_rx_i(uart_rx),
        .mem_if_o (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [4:0] wr_addr[$];
    logic [7:0] wr_data[$];
    int unsigned load_cnt = 0;
    int unsigned err_cnt  = 0;
    int unsigned we_run   = 0;
    int unsigned we_run_max = 0;
    logic [7:0] payload[$];
    int unsigned sum_adj = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_we) begin
                wr_addr.push_back(bus.mem_addr);
                wr_data.push_back(bus.mem_wdata);
                we_run++;
                if (we_run > we_run_max) we_run_max = we_run;
            end else begin
                we_run = 0;
            end
            if (bus.load_done) load_cnt++;
            if (bus.frame_err) err_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(posedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(posedge clk);
        uart_rx = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] base, input logic [7:0] len);
        logic [7:0] s;
        s = base + len;
        send_byte(8'hA5, 1'b1);
        send_byte(base, 1'b1);
        send_byte(len, 1'b1);
        foreach (payload[i]) begin
            send_byte(payload[i], 1'b1);
            s = s + payload[i];
        end
`ifdef LEG_LOADER_CHECKSUM_EN
        send_byte(s + 8'(sum_adj), 1'b1);
`endif
        repeat (2 * CPB) @(posedge clk);
    endtask

    task automatic chk_wr(input string tag, input int unsigned idx,
                          input logic [4:0] a, input logic [7:0] d);
        if (idx < wr_addr.size()) begin
            check({tag, "_addr"}, 32'(wr_addr[idx]), 32'(a));
            check({tag, "_data"}, 32'(wr_data[idx]), 32'(d));
        end else begin
            check({tag, "_missing"}, 32'(wr_addr.size()), 32'(idx + 1));
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        check(tag, {19'd0, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                    bus.cpu_run, bus.load_done, bus.frame_err}, 32'd0);
    endtask

    int unsigned w0, l0, e0;

    initial begin
        #23;
        chk_outputs_zero("reset_state");
        rst_n = 1'b1;
        repeat (10) @(posedge clk);

        // Basic frame: 01,00,42,00 at 0x10..0x13
        payload = '{8'h01, 8'h00, 8'h42, 8'h00};
        send_frame(8'h10, 8'h04);
        check("a_wr_count", wr_addr.size(), 4);
        chk_wr("a_w0", 0, 5'd16, 8'h01);
        chk_wr("a_w1", 1, 5'd17, 8'h00);
        chk_wr("a_w2", 2, 5'd18, 8'h42);
        chk_wr("a_w3", 3, 5'd19, 8'h00);
        check("a_load_done", load_cnt, 1);
        check("a_cpu_run", 32'(bus.cpu_run), 1);
        check("a_no_err", err_cnt, 0);
        check("a_we_single", we_run_max, 1);

        // Address wrap past 31
        w0 = wr_addr.size();
        payload = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_frame(8'h1E, 8'h04);
        check("b_wr_count", wr_addr.size() - w0, 4);
        chk_wr("b_w0", w0 + 0, 5'd30, 8'hAA);
        chk_wr("b_w1", w0 + 1, 5'd31, 8'hBB);
        chk_wr("b_w2", w0 + 2, 5'd0,  8'hCC);
        chk_wr("b_w3", w0 + 3, 5'd1,  8'hDD);
        check("b_load_done", load_cnt, 2);
        check("b_cpu_run", 32'(bus.cpu_run), 1);

        // Reload halts core; LEN=0x21 exceeds memory
        w0 = wr_addr.size();
        send_byte(8'hA5, 1'b1);
        check("c_halt", 32'(bus.cpu_run), 0);
        send_byte(8'h00, 1'b1);
        send_byte(8'h21, 1'b1);
        repeat (CPB) @(posedge clk);
        check("c_len_err", err_cnt, 1);
        check("c_cpu_run", 32'(bus.cpu_run), 0);
        check("c_no_write", wr_addr.size() - w0, 0);
        check("c_no_done", load_cnt, 2);

        // Bad stop bit inside GET_DATA
        w0 = wr_addr.size();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        repeat (2 * CPB) @(posedge clk);
        check("d_stop_err", err_cnt, 2);
        check("d_wr_count", wr_addr.size() - w0, 1);
        chk_wr("d_w0", w0, 5'd0, 8'h11);
        check("d_cpu_run", 32'(bus.cpu_run), 0);
        w0 = wr_addr.size();
        payload = '{8'h77};
        send_frame(8'h05, 8'h01);
        chk_wr("d_fresh", w0, 5'd5, 8'h77);
        check("d_load_done", load_cnt, 3);
        check("d_cpu_run_after", 32'(bus.cpu_run), 1);

        // Quarter-bit glitch on idle line
        w0 = wr_addr.size(); l0 = load_cnt; e0 = err_cnt;
        @(posedge clk);
        uart_rx = 1'b0;
        repeat (CPB / 4) @(posedge clk);
        uart_rx = 1'b1;
        repeat (12 * CPB) @(posedge clk);
        check("e_glitch_wr", wr_addr.size() - w0, 0);
        check("e_glitch_err", err_cnt - e0, 0);
        check("e_glitch_done", load_cnt - l0, 0);
        check("e_glitch_run", 32'(bus.cpu_run), 1);

        // Zero-length frame releases without writes
        w0 = wr_addr.size();
        payload = {};
        send_frame(8'h03, 8'h00);
        check("f_zero_wr", wr_addr.size() - w0, 0);
        check("f_zero_done", load_cnt, 4);
        check("f_zero_run", 32'(bus.cpu_run), 1);

        // Asynchronous reset in the middle of GET_DATA
        send_byte(8'hA5, 1'b1);
        send_byte(8'h08, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'hE1, 1'b1);
        check("g_pre_addr", 32'(bus.mem_addr), 32'd8);
        @(posedge clk);
        uart_rx = 1'b0;
        repeat (3 * CPB) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_outputs_zero("g_async_reset");
        uart_rx = 1'b1;
        repeat (3) @(posedge clk);
        chk_outputs_zero("g_reset_hold");
        #2 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        w0 = wr_addr.size(); l0 = load_cnt;
        payload = '{8'h5A, 8'hA5};
        send_frame(8'h0C, 8'h02);
        check("g_wr_count", wr_addr.size() - w0, 2);
        chk_wr("g_w0", w0 + 0, 5'd12, 8'h5A);
        chk_wr("g_w1", w0 + 1, 5'd13, 8'hA5);
        check("g_done", load_cnt - l0, 1);
        check("g_cpu_run", 32'(bus.cpu_run), 1);

`ifdef LEG_LOADER_CHECKSUM_EN
        // Checksum 08 good, 09 bad
        w0 = wr_addr.size(); l0 = load_cnt; e0 = err_cnt;
        payload = '{8'h07};
        sum_adj = 0;
        send_frame(8'h00, 8'h01);
        chk_wr("h_good_w", w0, 5'd0, 8'h07);
        check("h_good_done", load_cnt - l0, 1);
        check("h_good_run", 32'(bus.cpu_run), 1);
        w0 = wr_addr.size(); l0 = load_cnt;
        sum_adj = 1;
        send_frame(8'h00, 8'h01);
        chk_wr("h_bad_w", w0, 5'd0, 8'h07);
        check("h_bad_err", err_cnt - e0, 1);
        check("h_bad_done", load_cnt - l0, 0);
        check("h_bad_run", 32'(bus.cpu_run), 0);
`endif

        check("z_we_single", we_run_max, 1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
